triangle_scan: RTL and testbench

TRIANGLE_SCAN -- requirements
Module: triangle_scan

---
 rtl/triangle_scan.sv | 152 +++++++++++++++
 tb/tb_triangle_scan.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/triangle_scan.sv
// triangle_scan: walks the bounding box of a triangle in row-major order,
// presents each pixel to an external point-in-triangle checker, waits for the
// checker result to settle, then writes the result to the framebuffer.
module triangle_scan #(
    parameter int SETTLE = 64
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] ax,
    input  logic [8:0] ay,
    input  logic [8:0] bx,
    input  logic [8:0] by,
    input  logic [8:0] cx,
    input  logic [8:0] cy,
    output logic [8:0] px,
    output logic [8:0] py,
    input  logic       check,
    output logic       wr_en,
    output logic [8:0] wr_x,
    output logic [8:0] wr_y,
    output logic       wr_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, BBOX, DRIVE, WRITE, DONE} state_t;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
    } vtx_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

    state_t     state, state_nxt;
    vtx_t       va, vb, vc;
    logic [8:0] xmin, xmax, ymin, ymax;
    logic [8:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic [7:0] cnt;
    logic [8:0] wr_x_q, wr_y_q;
    logic       wr_data_q;
    logic       last_pt;
    logic       settled;

    function automatic logic [8:0] min3(input logic [8:0] a, b, c);
        logic [8:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [8:0] max3(input logic [8:0] a, b, c);
        logic [8:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bounding box of the latched vertices, captured during BBOX.
    assign bb_xmin = min3(va.x, vb.x, vc.x);
    assign bb_xmax = max3(va.x, vb.x, vc.x);
    assign bb_ymin = min3(va.y, vb.y, vc.y);
    assign bb_ymax = max3(va.y, vb.y, vc.y);

    // The final pixel never advances, so px/py cannot wrap past 511.
    assign last_pt = (px == xmax) && (py == ymax);
    assign settled = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BBOX;
            BBOX:    state_nxt = DRIVE;
            DRIVE:   if (settled) state_nxt = WRITE;
            WRITE:   state_nxt = last_pt ? DONE : DRIVE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vertex latch, bounding box, scan point, settle counter, write-back hold.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            va        <= '0;
            vb        <= '0;
            vc        <= '0;
            xmin      <= '0;
            xmax      <= '0;
            ymin      <= '0;
            ymax      <= '0;
            px        <= '0;
            py        <= '0;
            cnt       <= '0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_data_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        va <= '{x: ax, y: ay};
                        vb <= '{x: bx, y: by};
                        vc <= '{x: cx, y: cy};
                    end
                end
                BBOX: begin
                    xmin <= bb_xmin;
                    xmax <= bb_xmax;
                    ymin <= bb_ymin;
                    ymax <= bb_ymax;
                    px   <= bb_xmin;
                    py   <= bb_ymin;
                    cnt  <= '0;
                end
                DRIVE: begin
                    // Saturate at the terminal count; WRITE clears it.
                    if (!settled) cnt <= cnt + 8'd1;
                end
                WRITE: begin
                    wr_x_q    <= px;
                    wr_y_q    <= py;
                    wr_data_q <= check;
                    cnt       <= '0;
                    if (!last_pt) begin
                        if (px < xmax) begin
                            px <= px + 9'd1;
                        end else begin
                            px <= xmin;
                            py <= py + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Write port shows the live point during WRITE and holds it otherwise.
    assign wr_en   = (state == WRITE);
    assign wr_x    = wr_en ? px    : wr_x_q;
    assign wr_y    = wr_en ? py    : wr_y_q;
    assign wr_data = wr_en ? check : wr_data_q;
    assign busy    = (state == BBOX) || (state == DRIVE) || (state == WRITE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_triangle_scan.sv
// Directed bench for triangle_scan with SETTLE=4 and a checker stand-in that
// returns its point-in-triangle answer 4 cycles after px/py are presented.
module tb_triangle_scan;

    localparam int SETTLE = 4;
    localparam int PT     = SETTLE + 1;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       start    = 1'b0;
    logic [8:0] ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
    logic [8:0] px, py, wr_x, wr_y;
    logic       check, wr_en, wr_data, busy, done;

    triangle_scan #(.SETTLE(SETTLE)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .px(px), .py(py), .check(check),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Checker stand-in: triangle it judges against, independent of DUT inputs.
    int   t_ax, t_ay, t_bx, t_by, t_cx, t_cy;
    bit   force0 = 1'b0;
    logic [3:0] cpipe = '0;

    function automatic logic inside_tri(input int x, input int y);
        int e0, e1, e2;
        e0 = (t_bx - t_ax) * (y - t_ay) - (t_by - t_ay) * (x - t_ax);
        e1 = (t_cx - t_bx) * (y - t_by) - (t_cy - t_by) * (x - t_bx);
        e2 = (t_ax - t_cx) * (y - t_cy) - (t_ay - t_cy) * (x - t_cx);
        return ((e0 >= 0) && (e1 >= 0) && (e2 >= 0)) ||
               ((e0 <= 0) && (e1 <= 0) && (e2 <= 0));
    endfunction

    always @(posedge CLOCK_50) cpipe <= {cpipe[2:0], inside_tri(int'(px), int'(py))};
    assign check = force0 ? 1'b0 : cpipe[3];

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Captured writes of one scan, with cycle offset from BBOX entry.
    int wx[$], wy[$], wd[$], wc[$];
    int done_cyc, busy0, done_busy;

    task automatic set_tri(input int x0, y0, x1, y1, x2, y2);
        t_ax = x0; t_ay = y0; t_bx = x1; t_by = y1; t_cx = x2; t_cy = y2;
    endtask

    // Returns at the negedge inside the BBOX cycle (cycle offset 0).
    task automatic do_start(input int x0, y0, x1, y1, x2, y2);
        @(negedge CLOCK_50);
        start = 1'b1;
        ax = 9'(x0); ay = 9'(y0); bx = 9'(x1); by = 9'(y1); cx = 9'(x2); cy = 9'(y2);
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic collect(input int budget, input int pulse_cyc, input int rst_cyc);
        wx.delete(); wy.delete(); wd.delete(); wc.delete();
        done_cyc = -1; busy0 = 0; done_busy = -1;
        for (int c = 0; c < budget; c++) begin
            if (c > 0) @(negedge CLOCK_50);
            if (c == 0) busy0 = int'(busy);
            if (wr_en === 1'b1) begin
                wx.push_back(int'(wr_x)); wy.push_back(int'(wr_y));
                wd.push_back(int'(wr_data)); wc.push_back(c);
            end
            if (done === 1'b1) begin
                done_cyc = c; done_busy = int'(busy);
                break;
            end
            if (c == pulse_cyc) begin
                start = 1'b1;
                ax = 9'd0; ay = 9'd0; bx = 9'd50; by = 9'd0; cx = 9'd0; cy = 9'd50;
            end
            if (c == pulse_cyc + 1) start = 1'b0;
            if (c == rst_cyc) begin
                reset = 1'b1;
                #1;
                chk("rst_mid_wr_en", 32'(wr_en), 0);
                chk("rst_mid_busy", 32'(busy), 0);
                chk("rst_mid_done", 32'(done), 0);
                chk("rst_mid_px", 32'(px), 0);
            end
            if (c == rst_cyc + 2) reset = 1'b0;
        end
    endtask

    // mode 0: 3x3 hand pattern, 1: all ones, 2: all zeros.
    task automatic verify(input string tag, input int xmin, xmax, ymin, ymax,
                          input int mode, input int nexp, input int exp_done);
        bit pat [9];
        int w, ed;
        pat = '{1, 1, 1, 1, 1, 0, 1, 0, 0};
        w = xmax - xmin + 1;
        chk({tag, "_busy_bbox"}, 32'(busy0), 1);
        chk({tag, "_nwrites"}, 32'(wx.size()), 32'(nexp));
        for (int k = 0; k < nexp && k < wx.size(); k++) begin
            ed = (mode == 0) ? int'(pat[k]) : (mode == 1) ? 1 : 0;
            chk({tag, "_wr_x"}, 32'(wx[k]), 32'(xmin + k % w));
            chk({tag, "_wr_y"}, 32'(wy[k]), 32'(ymin + k / w));
            chk({tag, "_wr_data"}, 32'(wd[k]), 32'(ed));
            chk({tag, "_wr_cycle"}, 32'(wc[k]), 32'(PT * (k + 1)));
        end
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        if (exp_done >= 0) chk({tag, "_done_busy"}, 32'(done_busy), 0);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        #1;
        chk("rst_px", 32'(px), 0);
        chk("rst_py", 32'(py), 0);
        chk("rst_wr_x", 32'(wr_x), 0);
        chk("rst_wr_y", 32'(wr_y), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // Small right triangle, 3x3 box
        set_tri(10, 10, 12, 10, 10, 12);
        do_start(10, 10, 12, 10, 10, 12);
        collect(80, -1, -1);
        verify("basic", 10, 12, 10, 12, 0, 9, 46);
        @(negedge CLOCK_50);
        chk("basic_done_one_cycle", 32'(done), 0);
        chk("basic_idle_busy", 32'(busy), 0);
        chk("basic_hold_wr_x", 32'(wr_x), 12);
        chk("basic_hold_wr_y", 32'(wr_y), 12);

        // Single-point box at the coordinate ceiling
        set_tri(511, 511, 511, 511, 511, 511);
        do_start(511, 511, 511, 511, 511, 511);
        collect(40, -1, -1);
        verify("corner", 511, 511, 511, 511, 1, 1, 6);
        chk("corner_px_nowrap", 32'(px), 511);
        chk("corner_py_nowrap", 32'(py), 511);

        // Same triangle, vertices in reverse order
        set_tri(10, 12, 12, 10, 10, 10);
        do_start(10, 12, 12, 10, 10, 10);
        collect(80, -1, -1);
        verify("reverse", 10, 12, 10, 12, 0, 9, 46);

        // Second start mid-scan with other vertices is ignored
        set_tri(10, 10, 12, 10, 10, 12);
        do_start(10, 10, 12, 10, 10, 12);
        collect(80, 20, -1);
        verify("restart", 10, 12, 10, 12, 0, 9, 46);

        // Reset during the 5th DRIVE phase (cycles 21..24): 4 writes, no done
        do_start(10, 10, 12, 10, 10, 12);
        collect(70, -1, 22);
        verify("abort", 10, 12, 10, 12, 0, 4, -1);

        // Fresh scan after reset release
        do_start(10, 10, 12, 10, 10, 12);
        collect(80, -1, -1);
        verify("post_rst", 10, 12, 10, 12, 0, 9, 46);

        // Checker stuck at 0, 4x2 box
        force0 = 1'b1;
        set_tri(3, 5, 6, 5, 3, 6);
        do_start(3, 5, 6, 5, 3, 6);
        collect(80, -1, -1);
        verify("zero", 3, 6, 5, 6, 2, 8, 41);
        force0 = 1'b0;

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
